// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide engine: operation encodings,
// FSM state codes and small decode helpers used by the top level and by EX.
package muldiv_unit_pkg;

  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Signed operations have a zero in the low opcode bit.
  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

  // Divide operations have a one in the high opcode bit.
  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division step.
// Ports:
//   rem_in   partial remainder (always < divisor on entry)
//   bit_in   next dividend bit shifted into the partial remainder
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   q_bit    quotient bit produced by the step
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // Trial subtraction; a borrow (top bit set) means restore the partial remainder.
  always_comb begin
    partial = {rem_in, bit_in};
    trial   = partial - {1'b0, divisor};
    if (trial[WIDTH]) begin
      q_bit   = 1'b0;
      rem_out = partial[WIDTH-1:0];
    end else begin
      q_bit   = 1'b1;
      rem_out = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for the EX stage (MULT/MULTU/DIV/DIVU).
// Build option: MULDIV_ITER_MUL_EN selects a one-bit-per-cycle shift-add
// multiplier (latency WIDTH+1); undefined selects a single registered product.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       request and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   annul           abort current operation, return to IDLE
//   busy, done      in-progress flag, one-cycle completion pulse
//   hi, lo          product high/low or remainder/quotient
//   div_by_zero     divide had a zero divisor (valid with done)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  import muldiv_unit_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
`ifdef MULDIV_ITER_MUL_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(0);
`endif

  state_e                 state, next_state;
  logic                   accept;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_zero;
  // rem: partial remainder / product high half; quo: dividend->quotient / multiplier->product low half
  logic [WIDTH-1:0]       rem, quo, divisor, dividend_raw;
  logic                   neg_q, neg_r, b_zero;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH-1:0]       step_rem, q_mag, div_hi, div_lo;
  logic                   step_q;
  logic [WIDTH-1:0]       mul_rem_next, mul_quo_next;
  logic [2*WIDTH-1:0]     prod_mag, prod_res;

  assign cnt_zero = (cnt == {CNT_W{1'b0}});

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .bit_in  (quo[WIDTH-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state decode; annul overrides everything including a same-cycle start.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    if (annul) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            accept     = 1'b1;
            next_state = op_is_div(op) ? ST_DIV : ST_MUL;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_zero) begin
            next_state = ST_DONE;
          end else begin
            next_state = state;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Operand magnitudes and result fix-up (sign restore, divide-by-zero override).
  always_comb begin
    if (op_is_signed(op) && src_a[WIDTH-1]) begin
      mag_a = -src_a;
    end else begin
      mag_a = src_a;
    end
    if (op_is_signed(op) && src_b[WIDTH-1]) begin
      mag_b = -src_b;
    end else begin
      mag_b = src_b;
    end

    q_mag = {quo[WIDTH-2:0], step_q};
    if (b_zero) begin
      div_lo = {WIDTH{1'b1}};
      div_hi = dividend_raw;
    end else begin
      div_lo = neg_q ? -q_mag : q_mag;
      div_hi = neg_r ? -step_rem : step_rem;
    end

`ifdef MULDIV_ITER_MUL_EN
    // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right.
    begin
      logic [WIDTH:0] mul_sum;
      mul_sum      = {1'b0, rem} + (quo[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
      mul_rem_next = mul_sum[WIDTH:1];
      mul_quo_next = {mul_sum[0], quo[WIDTH-1:1]};
    end
    prod_mag = {mul_rem_next, mul_quo_next};
`else
    mul_rem_next = rem;
    mul_quo_next = quo;
    prod_mag     = {{WIDTH{1'b0}}, quo} * {{WIDTH{1'b0}}, divisor};
`endif
    prod_res = neg_q ? -prod_mag : prod_mag;
  end

  // State register and registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_MUL) || (next_state == ST_DIV);
      done  <= (next_state == ST_DONE);
    end
  end

  // Datapath: operand latch on accept, one iteration per cycle, results written on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= {CNT_W{1'b0}};
      rem          <= {WIDTH{1'b0}};
      quo          <= {WIDTH{1'b0}};
      divisor      <= {WIDTH{1'b0}};
      dividend_raw <= {WIDTH{1'b0}};
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      b_zero       <= 1'b0;
      hi           <= {WIDTH{1'b0}};
      lo           <= {WIDTH{1'b0}};
      div_by_zero  <= 1'b0;
    end else if (accept) begin
      cnt          <= op_is_div(op) ? DIV_LAST : MUL_LAST;
      rem          <= {WIDTH{1'b0}};
      quo          <= mag_a;
      divisor      <= mag_b;
      dividend_raw <= src_a;
      neg_q        <= op_is_signed(op) & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r        <= op_is_signed(op) & src_a[WIDTH-1];
      b_zero       <= (src_b == {WIDTH{1'b0}});
    end else if (!annul && state == ST_DIV) begin
      rem <= step_rem;
      quo <= q_mag;
      if (cnt_zero) begin
        hi          <= div_hi;
        lo          <= div_lo;
        div_by_zero <= b_zero;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (!annul && state == ST_MUL) begin
      rem <= mul_rem_next;
      quo <= mul_quo_next;
      if (cnt_zero) begin
        hi          <= prod_res[2*WIDTH-1:WIDTH];
        lo          <= prod_res[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors push expected
// {hi,lo,div_by_zero}; a negedge monitor pops and compares on every done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   lat, nbusy;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending op");
      end else begin
        e = exp_q.pop_front();
        check("hi", {32'h0, hi}, {32'h0, e.hi});
        check("lo", {32'h0, lo}, {32'h0, e.lo});
        check("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
      end
    end
  end

  // Call at a negedge: presents a request for one cycle, optionally records its expectation.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    exp_t e;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (push) begin
      e.hi = eh; e.lo = el; e.dbz = ed;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges (1 = first after start edge) until done; bounded.
  task automatic wait_done(output int l, output int nb);
    l = 1; nb = 0;
    while (done !== 1'b1 && l < 200) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      l++;
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got no done after %0d cycles, expected done", l);
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                     input logic ed, input int elat);
    issue(o, a, b, 1'b1, eh, el, ed);
    wait_done(lat, nbusy);
    check({name, "_latency"}, 64'(lat), 64'(elat));
    @(negedge clk);
    check({name, "_done_width"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; src_a = 32'h0; src_b = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_dbz", {63'h0, div_by_zero}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, MUL_LAT);
    run("mult_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, MUL_LAT);

    // DIV -7/2 with busy-width check
    issue(2'b10, 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done(lat, nbusy);
    check("div_latency", 64'(lat), 64'd33);
    check("div_busy_cycles", 64'(nbusy), 64'd32);
    check("div_busy_in_done", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check("div_done_width", {63'h0, done}, 64'h0);

    run("divu_zero", 2'b11, 32'd100, 32'h0, 32'h64, 32'hFFFFFFFF, 1'b1, 33);
    run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
    run("div_pos_neg", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 33);
    run("div_sgn_zero", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 33);
    run("div_neg_pos", 2'b10, 32'hFFFFFFF8, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 33);

    // Annul 10 cycles after start: no done, results retained, immediate restart
    issue(2'b11, 32'd9, 32'd4, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", {63'h0, busy}, 64'h0);
    check("annul_done", {63'h0, done}, 64'h0);
    check("annul_hilo_kept", {hi, lo}, 64'hFFFFFFFE_FFFFFFFE);
    run("after_annul", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0, 33);

    // annul and start together: annul wins
    op = 2'b11; src_a = 32'd9; src_b = 32'd4; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("annul_start_busy", {63'h0, busy}, 64'h0);

    // Back-to-back: start held through DONE
    issue(2'b11, 32'd9, 32'd4, 1'b1, 32'd1, 32'd2, 1'b0);
    start = 1'b1; src_a = 32'd100; src_b = 32'd7;
    exp_q.push_back('{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
    wait_done(lat, nbusy);
    check("b2b_first_latency", 64'(lat), 64'd33);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", {63'h0, busy}, 64'h1);
    wait_done(lat, nbusy);
    check("b2b_second_latency", 64'(lat), 64'd33);
    @(negedge clk);

    // Reset mid-operation
    issue(2'b10, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_dbz", {63'h0, div_by_zero}, 64'h0);
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", {63'h0, busy}, 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
